// File: rtl/decodifica_hamming_secded.sv
// Two-stage pipelined Hamming decoder: S1 registers codeword + syndrome/parity,
// S2 registers corrected data and error flags; saturating error counters on delivery.
module decodifica_hamming_secded #(
  parameter  int R      = 4,
  parameter  int SECDED = 1,
  parameter  int CONT_W = 16,
  localparam int N      = (1 << R) - 1,
  localparam int K      = N - R,
  localparam int W      = N + SECDED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entrada_valida,
  input  logic [W-1:0]      entrada,
  output logic              entrada_pronta,
  output logic              saida_valida,
  input  logic              saida_pronta,
  output logic [K-1:0]      saida,
  output logic [R-1:0]      sindrome,
  output logic              erro_corrigido,
  output logic              erro_duplo,
  input  logic              limpa_contadores,
  output logic [CONT_W-1:0] cont_corrigidos,
  output logic [CONT_W-1:0] cont_duplos
);

  localparam logic [CONT_W-1:0] C_MAX = '1;

  // Codeword index of the j-th data bit (non-power-of-two positions, ascending).
  function automatic int data_pos(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) res = p - 1;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  logic              r_v1;
  logic [N-1:0]      r_c1;
  logic [R-1:0]      r_s1;
  logic              r_p1;
  logic              r_v2;
  logic [K-1:0]      r_saida;
  logic [R-1:0]      r_sindrome;
  logic              r_corr;
  logic              r_duplo;
  logic [CONT_W-1:0] r_cont_c;
  logic [CONT_W-1:0] r_cont_d;

  logic              w_adv1;
  logic              w_adv2;
  logic              w_xfer;
  logic [R-1:0]      w_synd;
  logic              w_par;
  logic              w_s_nz;
  logic              w_do_flip;
  logic              w_corr;
  logic              w_dup;
  logic [N-1:0]      w_mask;
  logic [N-1:0]      w_fixed;
  logic [K-1:0]      w_data;

  assign w_adv2         = !r_v2 || saida_pronta;
  assign w_adv1         = !r_v1 || w_adv2;
  assign w_xfer         = r_v2 && saida_pronta;
  assign entrada_pronta = w_adv1;

  always_comb begin
    w_synd = '0;
    for (int p = 1; p <= N; p++) begin
      for (int k = 0; k < R; k++) begin
        if (p[k]) w_synd[k] = w_synd[k] ^ entrada[p-1];
      end
    end
  end

  generate
    if (SECDED != 0) begin : g_par
      assign w_par = ^entrada;
    end else begin : g_nopar
      assign w_par = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_c1 <= '0;
      r_s1 <= '0;
      r_p1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= entrada_valida;
      if (entrada_valida) begin
        r_c1 <= entrada[N-1:0];
        r_s1 <= w_synd;
        r_p1 <= w_par;
      end
    end
  end

  assign w_s_nz = |r_s1;

  // With SECDED, odd overall parity means a single error; s=0 then points at bit N.
  generate
    if (SECDED != 0) begin : g_secded
      assign w_do_flip = r_p1 && w_s_nz;
      assign w_corr    = r_p1;
      assign w_dup     = !r_p1 && w_s_nz;
    end else begin : g_sec
      assign w_do_flip = w_s_nz;
      assign w_corr    = w_s_nz;
      assign w_dup     = 1'b0;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_flip
      assign w_mask[gi] = w_do_flip && (r_s1 == R'(gi + 1));
    end
  endgenerate

  assign w_fixed = r_c1 ^ w_mask;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_data
      localparam int P = data_pos(gi);
      assign w_data[gi] = w_fixed[P];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2       <= 1'b0;
      r_saida    <= '0;
      r_sindrome <= '0;
      r_corr     <= 1'b0;
      r_duplo    <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_saida    <= w_data;
        r_sindrome <= r_s1;
        r_corr     <= w_corr;
        r_duplo    <= w_dup;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont_c <= '0;
      r_cont_d <= '0;
    end else if (limpa_contadores) begin
      r_cont_c <= '0;
      r_cont_d <= '0;
    end else if (w_xfer) begin
      if (r_corr && (r_cont_c != C_MAX)) r_cont_c <= r_cont_c + CONT_W'(1);
      if (r_duplo && (r_cont_d != C_MAX)) r_cont_d <= r_cont_d + CONT_W'(1);
    end
  end

  assign saida_valida    = r_v2;
  assign saida           = r_saida;
  assign sindrome        = r_sindrome;
  assign erro_corrigido  = r_corr;
  assign erro_duplo      = r_duplo;
  assign cont_corrigidos = r_cont_c;
  assign cont_duplos     = r_cont_d;

endmodule

// File: tb/tb_decodifica_hamming_secded.sv
// Bench for decodifica_hamming_secded: directed vectors, backpressure, reset, saturation,
// and randomized traffic scored against a position-XOR reference decoder.
module tb_decodifica_hamming_secded;

  typedef struct packed {
    logic [10:0] data;
    logic [3:0]  synd;
    logic        corr;
    logic        dup;
  } res_t;

  typedef struct {
    logic [15:0] cw;
    logic [10:0] d;
    logic [3:0]  s;
    logic        c;
    logic        u;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic limpa = 1'b0;

  // main (R=4, SECDED=1, CONT_W=16) and sat (same stream, CONT_W=2)
  logic m_valid = 1'b0, m_oready = 1'b1;
  logic [15:0] m_in = '0;
  logic m_ready, m_ovalid, m_corr, m_dup;
  logic [10:0] m_out;
  logic [3:0]  m_synd;
  logic [15:0] m_cc, m_cd;
  logic s_ready, s_ovalid, s_corr, s_dup;
  logic [10:0] s_out;
  logic [3:0]  s_synd;
  logic [1:0]  s_cc, s_cd;
  // R=3, SECDED=0
  logic x_valid = 1'b0, x_oready = 1'b1;
  logic [6:0] x_in = '0;
  logic x_ready, x_ovalid, x_corr, x_dup;
  logic [3:0]  x_out;
  logic [2:0]  x_synd;
  logic [15:0] x_cc, x_cd;

  int errors = 0;
  int checks = 0;
  res_t mq[$];
  res_t xq[$];
  int mcc, mcd, scc, scd, xcc, xcd;
  logic m_hold, x_hold;
  logic [17:0] m_prev;
  logic [9:0]  x_prev;
  vec_t tbl[7];
  logic [15:0] bp[3];

  always #5 clk = ~clk;

  decodifica_hamming_secded #(.R(4), .SECDED(1), .CONT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .entrada_valida(m_valid), .entrada(m_in), .entrada_pronta(m_ready),
    .saida_valida(m_ovalid), .saida_pronta(m_oready), .saida(m_out), .sindrome(m_synd),
    .erro_corrigido(m_corr), .erro_duplo(m_dup), .limpa_contadores(limpa),
    .cont_corrigidos(m_cc), .cont_duplos(m_cd));

  decodifica_hamming_secded #(.R(4), .SECDED(1), .CONT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .entrada_valida(m_valid), .entrada(m_in), .entrada_pronta(s_ready),
    .saida_valida(s_ovalid), .saida_pronta(m_oready), .saida(s_out), .sindrome(s_synd),
    .erro_corrigido(s_corr), .erro_duplo(s_dup), .limpa_contadores(limpa),
    .cont_corrigidos(s_cc), .cont_duplos(s_cd));

  decodifica_hamming_secded #(.R(3), .SECDED(0), .CONT_W(16)) u_r3 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(x_valid), .entrada(x_in), .entrada_pronta(x_ready),
    .saida_valida(x_ovalid), .saida_pronta(x_oready), .saida(x_out), .sindrome(x_synd),
    .erro_corrigido(x_corr), .erro_duplo(x_dup), .limpa_contadores(limpa),
    .cont_corrigidos(x_cc), .cont_duplos(x_cd));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: syndrome is the XOR of the positions of all set bits.
  function automatic res_t ref_decode(input logic [15:0] cw, input int r, input bit secded);
    res_t res;
    int n, s, j;
    bit par, flip;
    logic [15:0] c;
    n = (1 << r) - 1;
    c = cw;
    s = 0;
    par = 1'b0;
    for (int p = 1; p <= n; p++) if (c[p-1]) s = s ^ p;
    if (secded) for (int i = 0; i <= n; i++) par = par ^ c[i];
    res = '0;
    res.synd = 4'(s);
    if (!secded) begin
      res.corr = (s != 0);
      flip = (s != 0);
    end else begin
      res.corr = par;
      res.dup  = !par && (s != 0);
      flip     = par && (s != 0);
    end
    if (flip) c[s-1] = ~c[s-1];
    j = 0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        res.data[j] = c[p-1];
        j++;
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d, input int r, input bit secded);
    logic [15:0] c;
    int n, j, s;
    n = (1 << r) - 1;
    c = '0;
    j = 0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    s = 0;
    for (int p = 1; p <= n; p++) if (c[p-1]) s = s ^ p;
    for (int k = 0; k < r; k++) if (((s >> k) & 1) == 1) c[(1 << k) - 1] = 1'b1;
    if (secded) for (int i = 0; i < n; i++) c[n] = c[n] ^ c[i];
    return c;
  endfunction

  // Valid codeword with 0, 1 or 2 flipped bits.
  function automatic logic [15:0] gen(input int r, input bit secded);
    logic [15:0] c;
    int w, e, i, j;
    c = encode(11'($urandom), r, secded);
    w = (1 << r) - 1 + int'(secded);
    e = int'($urandom % 4);
    i = int'($urandom % w);
    j = (i + 1 + int'($urandom % (w - 1))) % w;
    if (e != 0) c[i] = ~c[i];
    if (e == 3) c[j] = ~c[j];
    return c;
  endfunction

  task automatic monitor();
    res_t e, ex;
    bit mx, xx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        xq.delete();
        mcc = 0; mcd = 0; scc = 0; scd = 0; xcc = 0; xcd = 0;
        m_hold = 1'b0;
        x_hold = 1'b0;
        check("reset_main", {m_ready, m_ovalid, m_out, m_synd, m_corr, m_dup, m_cc, m_cd}, {1'b1, 1'b0, 49'h0});
        check("reset_sat", {s_ready, s_ovalid, s_out, s_synd, s_corr, s_dup, s_cc, s_cd}, {1'b1, 1'b0, 21'h0});
        check("reset_r3", {x_ready, x_ovalid, x_out, x_synd, x_corr, x_dup, x_cc, x_cd}, {1'b1, 1'b0, 41'h0});
      end else begin
        check("cnt_main", {m_cc, m_cd}, {mcc[15:0], mcd[15:0]});
        check("cnt_sat", {s_cc, s_cd}, {scc[1:0], scd[1:0]});
        check("cnt_r3", {x_cc, x_cd}, {xcc[15:0], xcd[15:0]});
        check("ready_main", m_ready, (mq.size() < 2) || m_oready);
        check("ready_sat", s_ready, (mq.size() < 2) || m_oready);
        check("ready_r3", x_ready, (xq.size() < 2) || x_oready);
        if (m_hold) check("hold_main", {m_ovalid, m_out, m_synd, m_corr, m_dup}, m_prev);
        if (x_hold) check("hold_r3", {x_ovalid, x_out, x_synd, x_corr, x_dup}, x_prev);
        mx = 1'b0;
        xx = 1'b0;
        e = '0;
        ex = '0;
        if (m_ovalid && m_oready) begin
          if (mq.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_main: got word %h, expected none", m_out);
          end else begin
            e = mq.pop_front();
            mx = 1'b1;
            check("out_main", {m_out, m_synd, m_corr, m_dup}, e);
            check("out_sat", {s_ovalid, s_out, s_synd, s_corr, s_dup}, {1'b1, e});
            $display("tx main data=%h synd=%h corr=%0d dup=%0d", m_out, m_synd, m_corr, m_dup);
          end
        end
        if (x_ovalid && x_oready) begin
          if (xq.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_r3: got word %h, expected none", x_out);
          end else begin
            ex = xq.pop_front();
            xx = 1'b1;
            check("out_r3", {x_out, x_synd, x_corr, x_dup}, {ex.data[3:0], ex.synd[2:0], ex.corr, ex.dup});
            $display("tx r3   data=%h synd=%h corr=%0d dup=%0d", x_out, x_synd, x_corr, x_dup);
          end
        end
        if (limpa) begin
          mcc = 0; mcd = 0; scc = 0; scd = 0; xcc = 0; xcd = 0;
        end else begin
          if (mx && e.corr) begin
            if (mcc < 65535) mcc++;
            if (scc < 3) scc++;
          end
          if (mx && e.dup) begin
            if (mcd < 65535) mcd++;
            if (scd < 3) scd++;
          end
          if (xx && ex.corr && xcc < 65535) xcc++;
          if (xx && ex.dup && xcd < 65535) xcd++;
        end
        if (m_valid && m_ready) mq.push_back(ref_decode(m_in, 4, 1'b1));
        if (x_valid && x_ready) xq.push_back(ref_decode({9'h0, x_in}, 3, 1'b0));
        m_hold = m_ovalid && !m_oready;
        m_prev = {m_ovalid, m_out, m_synd, m_corr, m_dup};
        x_hold = x_ovalid && !x_oready;
        x_prev = {x_ovalid, x_out, x_synd, x_corr, x_dup};
      end
    end
  endtask

  // Single word into an empty pipeline: must appear exactly two edges after being driven.
  task automatic send_lat(input string name, input logic [15:0] cw, input res_t exp);
    @(posedge clk); #1;
    m_valid = 1'b1; m_in = cw; m_oready = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    check({name, "_lat1"}, m_ovalid, 1'b0);
    @(posedge clk); #1;
    check({name, "_lat2"}, {m_ovalid, m_out, m_synd, m_corr, m_dup}, {1'b1, exp});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before 300000");
    $fatal(1);
  end

  initial begin
    int idx;
    logic [15:0] g;
    tbl[0] = '{16'h0000, 11'h000, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 11'h7FF, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{16'h0020, 11'h000, 4'h6, 1'b1, 1'b0};
    tbl[3] = '{16'h8000, 11'h000, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{16'h0030, 11'h006, 4'h3, 1'b0, 1'b1};
    tbl[5] = '{16'h0004, 11'h000, 4'h3, 1'b1, 1'b0};
    tbl[6] = '{16'h4000, 11'h000, 4'hF, 1'b1, 1'b0};
    bp[0] = 16'h0020; bp[1] = 16'h0030; bp[2] = 16'hFFFF;

    fork
      monitor();
    join_none

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // SECDED=0, R=3: data bit at position 3 flipped
    @(posedge clk); #1;
    x_valid = 1'b1; x_in = 7'b0000100; x_oready = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(posedge clk); #1;
    check("r3_single", {x_ovalid, x_out, x_synd, x_corr, x_dup}, {1'b1, 4'h0, 3'h3, 1'b1, 1'b0});

    for (int i = 0; i < 7; i++)
      send_lat($sformatf("vec%0d", i), tbl[i].cw, {tbl[i].d, tbl[i].s, tbl[i].c, tbl[i].u});
    @(posedge clk); #1;
    check("cnt_after_tbl", {m_cc, m_cd}, {16'd4, 16'd1});
    check("sat_after_tbl", {s_cc, s_cd}, {2'd3, 2'd1});

    // Clear coinciding with a corrected transfer wins.
    m_valid = 1'b1; m_in = 16'h0020;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk); #1;
    limpa = 1'b1;
    @(posedge clk); #1;
    limpa = 1'b0;
    check("clear_wins", {m_cc, m_cd, s_cc, s_cd}, 36'h0);

    // Backpressure: 3 words offered with the consumer stalled.
    @(posedge clk); #1;
    m_oready = 1'b0; m_valid = 1'b1; idx = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      m_in = bp[idx];
      @(negedge clk);
      check("bp_ready", m_ready, (cyc < 2) ? 1'b1 : 1'b0);
      if (m_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", idx, 2);
    m_oready = 1'b1; m_in = bp[idx];
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check("bp_stream", m_ovalid, (cyc < 3) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      m_valid = 1'b0;
    end

    // Randomized traffic on both decoders.
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      m_valid = ($urandom % 4) != 0;
      m_in = gen(4, 1'b1);
      m_oready = ($urandom % 4) != 0;
      g = gen(3, 1'b0);
      x_valid = ($urandom % 4) != 0;
      x_in = g[6:0];
      x_oready = ($urandom % 3) != 0;
      limpa = ($urandom % 60) == 0;
    end
    @(posedge clk); #1;
    m_valid = 1'b0; x_valid = 1'b0; m_oready = 1'b1; x_oready = 1'b1; limpa = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("drain_main", mq.size(), 0);
    check("drain_r3", xq.size(), 0);

    // Asynchronous reset with both stages full.
    send_lat("pre_rst", 16'h0020, {11'h000, 4'h6, 1'b1, 1'b0});
    @(posedge clk); #1;
    m_oready = 1'b0; m_valid = 1'b1; m_in = 16'h0030;
    @(posedge clk); #1;
    m_in = 16'hFFFF;
    @(posedge clk); #1;
    m_valid = 1'b0;
    check("full_before_rst", {m_ovalid, m_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {m_ovalid, m_ready, m_cc, m_cd}, {1'b0, 1'b1, 32'h0});
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; m_oready = 1'b1;
    send_lat("post_rst", 16'h0030, {11'h006, 4'h3, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    #1;
    check("drain_end", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decodifica_hamming_secded.md
# decodifica_hamming_secded

Parametrised, pipelined Hamming decoder: successor to the fixed 15/11 combinational corrector. It accepts one codeword per cycle over a valid/ready handshake, computes the syndrome and optional overall parity, and corrects single-bit errors. In SECDED mode it also flags uncorrectable double errors. It keeps saturating error counters, and sits between the memory/link receive path and the data consumer.

## Interface
- R, 4: parity bits; N = 2^R−1 Hamming bits, K = N−R data bits (R in 3..6)
- SECDED, 1: 1 adds overall-parity bit at index N; codeword width W = N+SECDED
- CONT_W, 16: error counter width
- clk  in  1  clock; everything on rising edge
- rst_n  in  1  asynchronous, active-low reset
- entrada_valida  in  1  codeword present on entrada
- entrada  in  W  codeword; bit i = Hamming position i+1; parity at i = 2^k−1; bit N = overall even parity when SECDED=1
- entrada_pronta  out  1  decoder can accept this cycle
- saida_valida  out  1  result present
- saida_pronta  in  1  consumer accepts result
- saida  out  K  corrected data; data bits are non-parity positions in ascending index order (R=4: {c[14:8], c[6:4], c[2]})
- sindrome  out  R  syndrome of delivered word
- erro_corrigido  out  1  single error corrected (qualified by saida_valida)
- erro_duplo  out  1  double error detected, data uncorrected (always 0 if SECDED=0)
- limpa_contadores  in  1  synchronous counter clear
- cont_corrigidos  out  CONT_W  saturating count of delivered corrected words
- cont_duplos  out  CONT_W  saturating count of delivered double-error words

## Operation
- Stage 1 (S1) registers the codeword, syndrome s (bit k = XOR of all positions p with bit k of p set) and overall parity p (XOR of all W bits; forced 0 when SECDED=0).
- Stage 2 (S2) registers the result:
  - SECDED=0: s≠0 flips bit s−1; erro_corrigido = (s≠0).
  - SECDED=1, s=0 and p=0: no error.
  - SECDED=1, p=1: single error, erro_corrigido=1. If s≠0, flip bit s−1. If s=0, the error is in bit N and data is unchanged.
  - SECDED=1, s≠0 and p=0: erro_duplo=1, no flip; data is extracted raw.
- Each stage has a valid flag. S2 advances when !v2 or saida_pronta. S1 advances when !v1 or S2 advances.
- entrada_pronta = !v1 or (S2 advances). It is a combinational function of state and saida_pronta only, never of entrada_valida.
- Transfer occurs only on valid && pronta. Output registers hold while saida_valida && !saida_pronta.
- Counters increment only on an output transfer (saida_valida && saida_pronta) with the matching flag. They saturate at 2^CONT_W−1 and do not wrap.
- limpa_contadores zeroes both counters next edge. If it coincides with an increment, the clear wins (result 0).

## Timing
- Latency: word accepted at edge t is presented with saida_valida=1 after edge t+2. Throughput 1 word/cycle when saida_pronta=1.
- With saida_pronta held low, exactly 2 words are absorbed, then entrada_pronta=0.
- Order is strictly preserved; there is no loss or duplication under any stall pattern.
- Reset, asynchronous and effective immediately, including mid-stream: v1=v2=0, saida_valida=0, entrada_pronta=1 (combinational after reset), saida=0, sindrome=0, erro_corrigido=0, erro_duplo=0, both counters 0. In-flight words are discarded.
- Sideband outputs (sindrome, flags) change only with saida.

## Test plan
- R=4, SECDED=1. Stream 16'h0000 then 16'hFFFF with saida_pronta=1 → saida 11'h000 then 11'h7FF. Both at latency 2 with sindrome=0 and no flags.
- Single error: 16'h0020 → saida 11'h000, sindrome=4'h6, erro_corrigido=1, cont_corrigidos=1. Parity-bit error 16'h8000 → saida 0, sindrome 0, erro_corrigido=1.
- Double error: 16'h0030 → saida 11'h006, sindrome=4'h3, erro_duplo=1, erro_corrigido=0, cont_duplos=1.
- Backpressure: saida_pronta=0 while offering 3 words → 2 accepted, entrada_pronta=0. Release → all 3 delivered in order, 1 per cycle.
- CONT_W=2: 5 corrected words → cont_corrigidos sticks at 3. limpa_contadores asserted on the same cycle as a corrected transfer → 0.
- Assert rst_n low mid-stream with both stages full → saida_valida drops immediately, counters 0, and the next word after release has latency 2. Also run SECDED=0, R=3: 7'b0000100 → saida 4'h0 corrected.
